// File: rtl/multi_event_recovery_pkg.sv
// Shared types for the multi-event recovery block.
//   common_p    : clock-domain bundle (one clock plus async active-low reset).
//   clks_alot_p : recovery modes, pin-pair struct, channel FSM states and
//                 QUAD pin encodings.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom;

endpackage

package clks_alot_p;

  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    DIFF   = 2'd1,
    QUAD   = 2'd2
  } recovery_mode_e;

  typedef struct packed {
    logic pos;
    logic neg;
  } recovery_pins_s;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ACQUIRE  = 2'd1,
    TRACK    = 2'd2,
    FAULT    = 2'd3
  } chan_state_e;

  // QUAD {pos,neg} encodings, meaning given for polarity_select = 1
  localparam logic [1:0] QUAD_HIGH    = 2'b10;
  localparam logic [1:0] QUAD_LOW     = 2'b01;
  localparam logic [1:0] QUAD_IDLE    = 2'b00;
  localparam logic [1:0] QUAD_INVALID = 2'b11;

endpackage

// File: rtl/multi_event_recovery_erc_channel.sv
// erc_channel: one recovery channel -- pin decode, consecutive-sample filter,
// DISABLED/ACQUIRE/TRACK/FAULT FSM and stall counter.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             channel enable
//   polarity       1 = pos pin primary, 0 = neg pin primary
//   mode           SINGLE / DIFF / QUAD
//   pins           synchronised pin pair
//   stall_limit    stall threshold, 0 disables stall detection
//   fault_clear    fault acknowledge
//   rise/fall/edge_evt  registered single-cycle committed-edge pulses
//   fault          pin-integrity fault level (channel in FAULT)
//   stalled        stall level (TRACK only)
module erc_channel
  import clks_alot_p::*;
#(
  parameter int unsigned FILTER_CYCLES = 2,
  parameter int unsigned TIMEOUT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 polarity,
  input  recovery_mode_e       mode,
  input  recovery_pins_s       pins,
  input  logic [TIMEOUT_W-1:0] stall_limit,
  input  logic                 fault_clear,
  output logic                 rise,
  output logic                 fall,
  output logic                 edge_evt,
  output logic                 fault,
  output logic                 stalled
);

  localparam logic [3:0] FC = 4'(FILTER_CYCLES);

  chan_state_e          state;
  recovery_mode_e       prev_mode;
  logic                 prev_pol;
  logic                 level;
  logic                 cand;
  logic [3:0]           match_cnt;
  logic [3:0]           inv_cnt;
  logic [TIMEOUT_W-1:0] stall_cnt;

  logic       smp_level;
  logic       smp_valid;
  logic       smp_idle;
  logic       mode_change;
  logic       differs;
  logic [3:0] cnt_inc;

  always_comb begin
    smp_level = polarity ? pins.pos : pins.neg;
    smp_valid = 1'b1;
    smp_idle  = 1'b0;
    unique case (mode)
      DIFF: smp_valid = (pins.pos != pins.neg);
      QUAD: begin
        case ({pins.pos, pins.neg})
          QUAD_HIGH: smp_level = polarity;
          QUAD_LOW:  smp_level = !polarity;
          QUAD_IDLE: smp_idle  = 1'b1;
          default:   smp_valid = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign mode_change = (mode != prev_mode) || (polarity != prev_pol);
  // ACQUIRE has no committed level yet, so every valid sample is a candidate
  assign differs     = (state == ACQUIRE) || (smp_level != level);
  assign cnt_inc     = ((match_cnt != 4'd0) && (smp_level == cand)) ? match_cnt + 4'd1 : 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DISABLED;
      prev_mode <= SINGLE;
      prev_pol  <= 1'b0;
      level     <= 1'b0;
      cand      <= 1'b0;
      match_cnt <= '0;
      inv_cnt   <= '0;
      stall_cnt <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      edge_evt  <= 1'b0;
    end else begin
      prev_mode <= mode;
      prev_pol  <= polarity;
      rise      <= 1'b0;
      fall      <= 1'b0;
      edge_evt  <= 1'b0;
      if (!en) begin
        state     <= DISABLED;
        level     <= 1'b0;
        cand      <= 1'b0;
        match_cnt <= '0;
        inv_cnt   <= '0;
        stall_cnt <= '0;
      end else if (state == DISABLED || mode_change) begin
        state     <= ACQUIRE;
        match_cnt <= '0;
        inv_cnt   <= '0;
        stall_cnt <= '0;
      end else if (state == FAULT) begin
        if (fault_clear) begin
          state     <= ACQUIRE;
          match_cnt <= '0;
          inv_cnt   <= '0;
        end
      end else begin
        if (state == TRACK && stall_cnt != '1) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
        if (!smp_valid) begin
          // invalid samples hold the match count but accumulate toward FAULT
          if (inv_cnt + 4'd1 == FC) begin
            state     <= FAULT;
            match_cnt <= '0;
            inv_cnt   <= '0;
            stall_cnt <= '0;
          end else begin
            inv_cnt <= inv_cnt + 4'd1;
          end
        end else begin
          inv_cnt <= '0;
          if (smp_idle) begin
            match_cnt <= '0;
            stall_cnt <= '0;
          end else if (!differs) begin
            match_cnt <= '0;
          end else if (cnt_inc == FC) begin
            level     <= smp_level;
            match_cnt <= '0;
            stall_cnt <= '0;
            if (state == TRACK) begin
              rise     <= smp_level;
              fall     <= !smp_level;
              edge_evt <= 1'b1;
            end else begin
              state <= TRACK;
            end
          end else begin
            match_cnt <= cnt_inc;
            cand      <= smp_level;
          end
        end
      end
    end
  end

  assign fault   = (state == FAULT);
  assign stalled = (state == TRACK) && (stall_limit != '0) && (stall_cnt >= stall_limit);

endmodule

// File: rtl/multi_event_recovery.sv
// multi_event_recovery: CHANNELS independent edge-recovery channels sharing
// one clock domain. Reset assertion is asynchronous, release is synchronised.
// Ports:
//   sys_dom_i          clock + async active-low reset bundle
//   recovery_en_i      per-channel enable
//   polarity_select_i  per-channel primary pin select (1 = pos)
//   recovery_mode_i    per-channel SINGLE/DIFF/QUAD
//   io_clk_i           per-channel synchronised pin pairs
//   stall_limit_i      stall threshold shared by all channels (0 = off)
//   fault_clear_i      per-channel fault acknowledge
//   rise_o/fall_o/edge_o  committed-edge pulses
//   fault_o            per-channel fault level
//   stalled_o          per-channel stall level
module multi_event_recovery
  import clks_alot_p::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned FILTER_CYCLES = 2,
  parameter int unsigned TIMEOUT_W     = 16
) (
  input  common_p::clk_dom                sys_dom_i,
  input  logic           [CHANNELS-1:0]   recovery_en_i,
  input  logic           [CHANNELS-1:0]   polarity_select_i,
  input  recovery_mode_e [CHANNELS-1:0]   recovery_mode_i,
  input  recovery_pins_s [CHANNELS-1:0]   io_clk_i,
  input  logic           [TIMEOUT_W-1:0]  stall_limit_i,
  input  logic           [CHANNELS-1:0]   fault_clear_i,
  output logic           [CHANNELS-1:0]   rise_o,
  output logic           [CHANNELS-1:0]   fall_o,
  output logic           [CHANNELS-1:0]   edge_o,
  output logic           [CHANNELS-1:0]   fault_o,
  output logic           [CHANNELS-1:0]   stalled_o
);

  logic       clk;
  logic       rst_async_n;
  logic [1:0] rst_sync;
  logic       rst_n;

  assign clk         = sys_dom_i.clk;
  assign rst_async_n = sys_dom_i.rst_n;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    erc_channel #(
      .FILTER_CYCLES(FILTER_CYCLES),
      .TIMEOUT_W    (TIMEOUT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (recovery_en_i[g]),
      .polarity   (polarity_select_i[g]),
      .mode       (recovery_mode_i[g]),
      .pins       (io_clk_i[g]),
      .stall_limit(stall_limit_i),
      .fault_clear(fault_clear_i[g]),
      .rise       (rise_o[g]),
      .fall       (fall_o[g]),
      .edge_evt   (edge_o[g]),
      .fault      (fault_o[g]),
      .stalled    (stalled_o[g])
    );
  end

endmodule

// File: tb/tb_multi_event_recovery.sv
// Directed, table-driven bench for multi_event_recovery (4 channels, filter 2).
module tb_multi_event_recovery;
  import clks_alot_p::*;

  logic                  clk;
  logic                  rst_n;
  common_p::clk_dom      dom;
  logic           [3:0]  en;
  logic           [3:0]  pol;
  recovery_mode_e [3:0]  mode;
  recovery_pins_s [3:0]  pins;
  logic           [15:0] stall_limit;
  logic           [3:0]  clr;
  logic           [3:0]  rise_o, fall_o, edge_o, fault_o, stalled_o;

  assign dom.clk   = clk;
  assign dom.rst_n = rst_n;

  multi_event_recovery #(
    .CHANNELS     (4),
    .FILTER_CYCLES(2),
    .TIMEOUT_W    (16)
  ) dut (
    .sys_dom_i        (dom),
    .recovery_en_i    (en),
    .polarity_select_i(pol),
    .recovery_mode_i  (mode),
    .io_clk_i         (pins),
    .stall_limit_i    (stall_limit),
    .fault_clear_i    (clr),
    .rise_o           (rise_o),
    .fall_o           (fall_o),
    .edge_o           (edge_o),
    .fault_o          (fault_o),
    .stalled_o        (stalled_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {rise, fall, edge, fault, stalled} for the addressed channel
  localparam logic [4:0] E0 = 5'b00000;
  localparam logic [4:0] ER = 5'b10100;
  localparam logic [4:0] EF = 5'b01100;
  localparam logic [4:0] EX = 5'b00010;

  typedef struct {
    int unsigned    ch;
    logic           en;
    logic           pol;
    recovery_mode_e mode;
    logic [1:0]     pins;
    logic           clr;
    logic [4:0]     exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input int unsigned ch, input logic e, input logic p, input recovery_mode_e m,
                     input logic [1:0] pn, input logic c, input logic [4:0] x);
    vec_t v;
    v.ch = ch; v.en = e; v.pol = p; v.mode = m; v.pins = pn; v.clr = c; v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [19:0] act, input logic [19:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, want %h ({rise,fall,edge,fault,stalled})", name, idx, act, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {rise_o, fall_o, edge_o, fault_o, stalled_o};
  endfunction

  task automatic drive_idle();
    en = '0; pol = '0; clr = '0; pins = '0;
    for (int k = 0; k < 4; k++) mode[k] = SINGLE;
  endtask

  task automatic drive_vec(input vec_t v);
    drive_idle();
    en[v.ch]   = v.en;
    pol[v.ch]  = v.pol;
    mode[v.ch] = v.mode;
    pins[v.ch] = v.pins;
    clr[v.ch]  = v.clr;
  endtask

  // all channels SINGLE, pos primary, neg pin low
  task automatic drive_single(input logic [3:0] e, input logic [3:0] pos);
    drive_idle();
    en  = e;
    pol = '1;
    for (int k = 0; k < 4; k++) pins[k] = {pos[k], 1'b0};
  endtask

  function automatic logic [19:0] exp_bus(input vec_t v);
    logic [3:0] m;
    m = 4'b0001 << v.ch;
    return {v.exp[4] ? m : 4'b0, v.exp[3] ? m : 4'b0, v.exp[2] ? m : 4'b0,
            v.exp[1] ? m : 4'b0, v.exp[0] ? m : 4'b0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ch0 SINGLE: acquire, rise (t+2), glitch, secondary ignored, fall, polarity swap
    add(0,1,1,SINGLE,2'b00,0,E0); add(0,1,1,SINGLE,2'b00,0,E0); add(0,1,1,SINGLE,2'b00,0,E0);
    add(0,1,1,SINGLE,2'b10,0,E0); add(0,1,1,SINGLE,2'b10,0,E0); add(0,1,1,SINGLE,2'b10,0,ER);
    add(0,1,1,SINGLE,2'b00,0,E0); add(0,1,1,SINGLE,2'b11,0,E0); add(0,1,1,SINGLE,2'b11,0,E0);
    add(0,1,1,SINGLE,2'b00,0,E0); add(0,1,1,SINGLE,2'b00,0,E0); add(0,1,1,SINGLE,2'b00,0,EF);
    add(0,1,0,SINGLE,2'b00,0,E0); add(0,1,0,SINGLE,2'b01,0,E0); add(0,1,0,SINGLE,2'b01,0,E0);
    add(0,1,0,SINGLE,2'b01,0,E0); add(0,1,0,SINGLE,2'b10,0,E0); add(0,1,0,SINGLE,2'b10,0,E0);
    add(0,1,0,SINGLE,2'b10,0,EF); add(0,0,1,SINGLE,2'b00,0,E0); add(0,0,1,SINGLE,2'b00,0,E0);
    // ch1 DIFF: invalid holds filter, fault, clear, silent re-acquire, clear outside FAULT
    add(1,1,1,DIFF,2'b10,0,E0); add(1,1,1,DIFF,2'b10,0,E0); add(1,1,1,DIFF,2'b10,0,E0);
    add(1,1,1,DIFF,2'b11,0,E0); add(1,1,1,DIFF,2'b01,0,E0); add(1,1,1,DIFF,2'b11,0,E0);
    add(1,1,1,DIFF,2'b01,0,E0); add(1,1,1,DIFF,2'b01,0,EF); add(1,1,1,DIFF,2'b11,0,E0);
    add(1,1,1,DIFF,2'b11,0,E0); add(1,1,1,DIFF,2'b10,0,EX); add(1,1,1,DIFF,2'b10,0,EX);
    add(1,1,1,DIFF,2'b10,1,EX); add(1,1,1,DIFF,2'b10,0,E0); add(1,1,1,DIFF,2'b10,0,E0);
    add(1,1,1,DIFF,2'b10,0,E0); add(1,1,1,DIFF,2'b10,1,E0); add(1,1,1,DIFF,2'b01,0,E0);
    add(1,1,1,DIFF,2'b01,0,E0); add(1,0,1,DIFF,2'b01,0,EF); add(1,0,1,DIFF,2'b01,0,E0);
    // ch2 QUAD pos primary: low->high rise, idle holds level, idle restarts filter, fault
    add(2,1,1,QUAD,2'b01,0,E0); add(2,1,1,QUAD,2'b01,0,E0); add(2,1,1,QUAD,2'b01,0,E0);
    add(2,1,1,QUAD,2'b10,0,E0); add(2,1,1,QUAD,2'b10,0,E0); add(2,1,1,QUAD,2'b10,0,ER);
    add(2,1,1,QUAD,2'b00,0,E0); add(2,1,1,QUAD,2'b10,0,E0); add(2,1,1,QUAD,2'b00,0,E0);
    add(2,1,1,QUAD,2'b01,0,E0); add(2,1,1,QUAD,2'b00,0,E0); add(2,1,1,QUAD,2'b01,0,E0);
    add(2,1,1,QUAD,2'b01,0,E0); add(2,1,1,QUAD,2'b01,0,EF); add(2,1,1,QUAD,2'b11,0,E0);
    add(2,1,1,QUAD,2'b11,0,E0); add(2,1,1,QUAD,2'b11,0,EX); add(2,1,1,QUAD,2'b10,1,EX);
    add(2,0,1,QUAD,2'b10,0,E0); add(2,0,1,QUAD,2'b10,0,E0);
    // ch3 QUAD neg primary (swapped meaning), then mode change forces silent ACQUIRE
    add(3,1,0,QUAD,2'b10,0,E0); add(3,1,0,QUAD,2'b10,0,E0); add(3,1,0,QUAD,2'b10,0,E0);
    add(3,1,0,QUAD,2'b01,0,E0); add(3,1,0,QUAD,2'b01,0,E0); add(3,1,0,QUAD,2'b01,0,ER);
    add(3,1,0,DIFF,2'b01,0,E0); add(3,1,0,DIFF,2'b01,0,E0); add(3,1,0,DIFF,2'b01,0,E0);
    add(3,1,0,DIFF,2'b01,0,E0); add(3,0,1,SINGLE,2'b00,0,E0); add(3,0,1,SINGLE,2'b00,0,E0);

    // reset state
    rst_n = 1'b0;
    stall_limit = '0;
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset", c, outs(), '0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check("post_reset", c, outs(), '0);
    end

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive_vec(vecs[i]);
      @(negedge clk);
      check("vec", i, outs(), exp_bus(vecs[i]));
    end

    // stall on ch0: limit 5, commit at c15 clears it, re-stalls 5 cycles later
    stall_limit = 16'd5;
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk); #1;
      drive_single(4'b0001, (c >= 13) ? 4'b0001 : 4'b0000);
      @(negedge clk);
      check("stall", c, outs(), {(c == 15) ? 4'b0001 : 4'b0000, 4'b0000,
                                 (c == 15) ? 4'b0001 : 4'b0000, 4'b0000,
                                 ((c >= 8 && c < 15) || c >= 20) ? 4'b0001 : 4'b0000});
    end
    stall_limit = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      drive_single(4'b0001, 4'b0001);
      @(negedge clk);
      check("stall_off", c, outs(), '0);
    end
    stall_limit = 16'd5;
    #1;
    check("stall_on", 0, outs(), {16'h0, 4'b0001});
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      drive_single(4'b0000, 4'b0000);
      @(negedge clk);
    end
    check("stall_disabled", 0, outs(), '0);
    stall_limit = '0;

    // simultaneous rise on all channels, then async reset with pulses visible
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk); #1;
      drive_single(4'b1111, (c >= 4) ? 4'b1111 : 4'b0000);
      @(negedge clk);
      check("all_rise", c, outs(), {(c == 6) ? 4'hF : 4'h0, 4'h0, (c == 6) ? 4'hF : 4'h0, 8'h00});
    end
    #1 rst_n = 1'b0;
    #1 check("async_reset", 0, outs(), '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("in_reset", c, outs(), '0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      drive_single(4'b1111, 4'b1111);
      @(negedge clk);
      check("reacquire", c, outs(), '0);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive_single(4'b1111, 4'b0000);
      @(negedge clk);
      check("all_fall", c, outs(), {4'h0, (c == 2) ? 4'hF : 4'h0, (c == 2) ? 4'hF : 4'h0, 8'h00});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_event_recovery.md
MULTI_EVENT_RECOVERY -- requirements
Module: multi_event_recovery

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent recovery channels, range 1..32.
REQ-002 Parameter FILTER_CYCLES, default 2: consecutive identical samples required to commit a level, range 1..15.
REQ-003 Parameter TIMEOUT_W, default 16: width of the stall counter and stall limit.
REQ-004 sys_dom_i  in  common_p::clk_dom  one system clock plus reset; reset SHALL be asynchronous and active-low.
REQ-005 recovery_en_i  in  CHANNELS  per-channel enable.
REQ-006 polarity_select_i  in  CHANNELS  per-channel primary select: 1 = pos pin primary, 0 = neg pin primary.
REQ-007 recovery_mode_i  in  CHANNELS x clks_alot_p::recovery_mode_e  per-channel mode: SINGLE, DIFF or QUAD.
REQ-008 io_clk_i  in  CHANNELS x clks_alot_p::recovery_pins_s  synchronised pin pairs (pos, neg).
REQ-009 stall_limit_i  in  TIMEOUT_W  cycles without a committed edge before stall; 0 disables stall detection.
REQ-010 fault_clear_i  in  CHANNELS  per-channel single-cycle fault acknowledge.
REQ-011 rise_o / fall_o / edge_o  out  CHANNELS each  single-cycle committed-edge pulses.
REQ-012 fault_o  out  CHANNELS  sticky per-channel pin-integrity fault.
REQ-013 stalled_o  out  CHANNELS  per-channel stall level.

Function
REQ-014 Each channel SHALL run an FSM: DISABLED, ACQUIRE, TRACK, FAULT.
REQ-015 DISABLED -> ACQUIRE when enabled; any state -> DISABLED on the first cycle enable is low. Entering DISABLED clears filter, counter, fault and stall.
REQ-016 In ACQUIRE the first committed level SHALL be stored without an event pulse, then -> TRACK.
REQ-017 SINGLE mode: only the primary pin is sampled; the secondary pin is ignored.
REQ-018 DIFF mode: the sample is the primary pin; a pin pair with pos==neg is invalid. Invalid samples SHALL NOT advance the filter.
REQ-019 QUAD mode: {pos,neg} 10 = high, 01 = low, 00 = idle, 11 = invalid. polarity_select_i SHALL swap the high/low meaning. Idle holds the committed level and clears the stall counter.
REQ-020 Filter: a candidate level that differs from the committed level SHALL commit after FILTER_CYCLES consecutive valid samples of that level. A differing sample restarts the count.
REQ-021 A commit in TRACK SHALL pulse rise_o or fall_o, and edge_o, for exactly one cycle. The pulse is registered in the cycle after the FILTER_CYCLES-th qualifying sample.
REQ-022 Latency: the first new-level sample at cycle t SHALL give a pulse at cycle t+FILTER_CYCLES.
REQ-023 FILTER_CYCLES consecutive invalid samples (DIFF or QUAD) SHALL move any active state to FAULT. In the following cycle fault_o=1 and pulses are suppressed.
REQ-024 FAULT -> ACQUIRE on fault_clear_i; fault_o SHALL drop in the next cycle. A clear outside FAULT has no effect.
REQ-025 In TRACK the stall counter SHALL increment each cycle, saturate at all-ones, and reset to 0 on a commit.
REQ-026 stalled_o SHALL be 1 while counter >= stall_limit_i and stall_limit_i != 0, and 0 in every non-TRACK state.
REQ-027 A mode or polarity change while enabled SHALL force ACQUIRE in the next cycle without a pulse.
REQ-028 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported in the same cycle.

Reset
REQ-029 Asynchronous assertion SHALL force all channels to DISABLED and clear filter and stall counters.
REQ-030 All outputs SHALL be 0 during reset and in the first cycle after deassertion.
REQ-031 Deassertion SHALL be released synchronously to sys_dom_i.

Structure
REQ-032 The channel state enum and the QUAD encoding constants SHALL live in clks_alot_p.
REQ-033 One sub-module, erc_channel, SHALL hold the per-channel FSM, filter and stall counter. The top level instantiates CHANNELS copies via generate.

Verification
REQ-034 CHANNELS=4, FILTER_CYCLES=2, SINGLE, pos primary: pos 0->1 at cycle 10 -> rise_o[0] and edge_o[0] high only in cycle 12.
REQ-035 Glitch: a 1-cycle pos pulse with FILTER_CYCLES=2 -> no event pulse.
REQ-036 DIFF ch1: pos=neg=1 held for 2 cycles -> fault_o[1]=1 and events suppressed; fault_clear_i[1] -> fault_o[1]=0 next cycle, ACQUIRE, first commit gives no pulse.
REQ-037 QUAD ch2: 01->10 -> rise; 10->00->10 -> no pulse; 11 held for 2 cycles -> fault.
REQ-038 Stall: stall_limit_i=5 with no edges -> stalled_o rises after 5 cycles in TRACK; a commit clears it; stall_limit_i=0 never stalls.
REQ-039 Reset asserted mid-TRACK with pulses pending -> all outputs 0 immediately; ACQUIRE without spurious pulses after release.
